// File: rtl/bus_pkg.sv
// +-----------------------------------------------------------------------+
// | bus_pkg : shared types and constants for the crypto byte-bus endpoint |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package bus_pkg;

  localparam logic [1:0] ID_B    = 2'b00;
  localparam logic [1:0] ID_SHA  = 2'b01;
  localparam logic [1:0] ID_CTRL = 2'b11;

  localparam int ID_W         = 2;
  localparam int HDR_DEST_MSB = 7;
  localparam int HDR_DEST_LSB = 6;
  localparam int HDR_SRC_MSB  = 5;
  localparam int HDR_SRC_LSB  = 4;
  localparam int HDR_LEN_MSB  = 3;
  localparam int HDR_LEN_LSB  = 0;
  localparam int MAX_LEN      = 16;
  localparam int CNT_W        = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_SKIP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0] src;
    logic            last;
    logic [7:0]      data;
  } fifo_word_t;

endpackage

`default_nettype wire

// File: rtl/frame_fifo.sv
// +-----------------------------------------------------------------------+
// | frame_fifo : payload FIFO with speculative write and commit/rollback  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module frame_fifo
  import bus_pkg::*;
#(
  parameter int  DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  fifo_word_t wr_word,
  input  logic       commit,
  input  logic       rollback,
  input  logic       rd_en,
  output fifo_word_t rd_word,
  output logic       rd_valid,
  output logic [PW-1:0] free
);

  logic [PW-1:0] spec_wr_q, spec_wr_d;
  logic [PW-1:0] com_wr_q, com_wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          pop;
  fifo_word_t    mem_q [DEPTH];

  // Commit publishes the speculative pointer including a write in the same cycle.
  always_comb begin
    rd_valid  = (rd_q != com_wr_q);
    pop       = rd_valid && rd_en;
    spec_wr_d = rollback ? com_wr_q : spec_wr_q + PW'(wr_en);
    com_wr_d  = commit ? spec_wr_d : com_wr_q;
    rd_d      = rd_q + PW'(pop);
    free      = PW'(DEPTH) - (com_wr_q - rd_q);
    rd_word   = rd_valid ? mem_q[rd_q[AW-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[spec_wr_q[AW-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_wr_q <= '0;
      com_wr_q  <= '0;
      rd_q      <= '0;
    end else begin
      spec_wr_q <= spec_wr_d;
      com_wr_q  <= com_wr_d;
      rd_q      <= rd_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_frame_responder.sv
// +-----------------------------------------------------------------------+
// | bus_frame_responder : byte-bus frame parser, buffers own-ID payloads  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module bus_frame_responder
  import bus_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] my_id,
  input  logic [7:0]      bus_data,
  input  logic            bus_valid,
  output logic            ack,
  output logic            out_valid,
  output logic [7:0]      out_data,
  output logic            out_last,
  output logic [ID_W-1:0] out_src,
  input  logic            out_ready,
  output logic [7:0]      drop_cnt
);

  localparam int         PW         = $clog2(DEPTH) + 1;
  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [7:0]       idle_q, idle_d;
  logic [7:0]       drop_q, drop_d;
  logic [ID_W-1:0]  src_q, src_d;
  logic             ack_q, ack_d;

  logic             wr_en, commit, rollback, drop_inc;
  logic [PW-1:0]    free, hdr_len;
  logic [ID_W-1:0]  hdr_dest, hdr_src;
  fifo_word_t       wr_word, rd_word;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    idle_d   = idle_q;
    src_d    = src_q;
    ack_d    = 1'b0;
    wr_en    = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    drop_inc = 1'b0;
    hdr_dest = bus_data[HDR_DEST_MSB:HDR_DEST_LSB];
    hdr_src  = bus_data[HDR_SRC_MSB:HDR_SRC_LSB];
    hdr_len  = PW'(bus_data[HDR_LEN_MSB:HDR_LEN_LSB]) + PW'(1);

    case (state_q)
      ST_IDLE: begin
        if (bus_valid) begin
          rem_d  = CNT_W'(bus_data[HDR_LEN_MSB:HDR_LEN_LSB]) + CNT_W'(1);
          idle_d = '0;
          src_d  = hdr_src;
          if (hdr_dest == my_id) begin
            if (free >= hdr_len) begin
              state_d = ST_RECV;
            end else begin
              state_d  = ST_SKIP;
              drop_inc = 1'b1;
            end
          end else begin
            state_d = ST_SKIP;
          end
        end
      end
      ST_RECV, ST_SKIP: begin
        if (bus_valid) begin
          idle_d = '0;
          rem_d  = rem_q - CNT_W'(1);
          wr_en  = (state_q == ST_RECV);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            commit  = (state_q == ST_RECV);
            ack_d   = (state_q == ST_RECV);
          end
        end else if (idle_q == IDLE_LIMIT) begin
          // Only a partially received own frame has anything to undo.
          state_d  = ST_IDLE;
          rollback = (state_q == ST_RECV);
          drop_inc = (state_q == ST_RECV);
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    drop_d = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      idle_q  <= '0;
      drop_q  <= '0;
      src_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idle_q  <= idle_d;
      drop_q  <= drop_d;
      src_q   <= src_d;
      ack_q   <= ack_d;
    end
  end

  assign wr_word = '{src: src_q, last: (rem_q == CNT_W'(1)), data: bus_data};

  frame_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_word  (wr_word),
    .commit   (commit),
    .rollback (rollback),
    .rd_en    (out_ready),
    .rd_word  (rd_word),
    .rd_valid (out_valid),
    .free     (free)
  );

  assign ack      = ack_q;
  assign out_data = rd_word.data;
  assign out_last = rd_word.last;
  assign out_src  = rd_word.src;
  assign drop_cnt = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_frame_responder.sv
// +-----------------------------------------------------------------------+
// | tb_bus_frame_responder : directed self-checking bench                 |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_bus_frame_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] my_id = 2'b01;
  logic [7:0] bus_data = 8'h00;
  logic       bus_valid = 1'b0;
  logic       ack;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] out_src;
  logic       out_ready = 1'b0;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bus_frame_responder #(
    .DEPTH   (32),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .my_id     (my_id),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one bus cycle; returns 1 time unit after the sampling edge.
  task automatic bus(input logic v, input logic [7:0] d);
    @(negedge clk);
    bus_valid = v;
    bus_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pop();
    @(negedge clk);
    bus_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [7:0] d, input logic l, input logic [1:0] s);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_last"},  32'(out_last),  32'(l));
    check({tag, "_src"},   32'(out_src),   32'(s));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   32'(ack),       32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_src",   32'(out_src),   32'd0);
    check("rst_drop",  32'(drop_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-byte frame
    bus(1'b1, 8'h40);
    check("t1_hdr_ack",   32'(ack),       32'd0);
    check("t1_hdr_valid", 32'(out_valid), 32'd0);
    bus(1'b1, 8'hA5);
    check("t1_ack", 32'(ack), 32'd1);
    check_head("t1_head", 8'hA5, 1'b1, 2'b00);
    bus(1'b0, 8'h00);
    check("t1_ack_end", 32'(ack), 32'd0);
    pop();
    check("t1_empty", 32'(out_valid), 32'd0);

    // Maximum-length frame from src 11
    bus(1'b1, 8'h7F);
    for (int i = 0; i < 16; i++) begin
      bus(1'b1, 8'(i));
      if (i == 14) check("t2_ack_early", 32'(ack), 32'd0);
    end
    check("t2_ack", 32'(ack), 32'd1);
    bus(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      check_head($sformatf("t2_b%0d", i), 8'(i), (i == 15), 2'b11);
      pop();
    end
    check("t2_empty", 32'(out_valid), 32'd0);

    // Frame for another ID is skipped
    bus(1'b1, 8'hC0);
    check("t2s_hdr_ack", 32'(ack), 32'd0);
    bus(1'b1, 8'h55);
    check("t2s_ack",   32'(ack),       32'd0);
    check("t2s_valid", 32'(out_valid), 32'd0);
    bus(1'b0, 8'h00);
    check("t2s_ack2", 32'(ack),      32'd0);
    check("t2s_drop", 32'(drop_cnt), 32'd0);

    // Overflow: two full frames fill the FIFO
    out_ready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      bus(1'b1, 8'h4F);
      for (int i = 0; i < 16; i++) bus(1'b1, 8'(f * 8'h80 + i));
      check($sformatf("t3_ack%0d", f), 32'(ack), 32'd1);
    end
    bus(1'b1, 8'h40);
    check("t3_drop",    32'(drop_cnt), 32'd1);
    check("t3_hdr_ack", 32'(ack),      32'd0);
    bus(1'b1, 8'h40);
    check("t3_pay_ack", 32'(ack), 32'd0);
    bus(1'b0, 8'h00);
    check("t3_drop2", 32'(drop_cnt), 32'd1);
    check("t3_ack2",  32'(ack),      32'd0);
    for (int i = 0; i < 32; i++) begin
      check_head($sformatf("t3_b%0d", i),
                 (i < 16) ? 8'(i) : 8'(8'h80 + i - 16), (i % 16 == 15), 2'b00);
      pop();
    end
    check("t3_empty", 32'(out_valid), 32'd0);

    // Timeout mid-frame rolls back
    bus(1'b1, 8'h43);
    bus(1'b1, 8'h01);
    bus(1'b1, 8'h02);
    repeat (14) bus(1'b0, 8'h00);
    check("t4_drop_pre", 32'(drop_cnt), 32'd1);
    bus(1'b0, 8'h00);
    check("t4_drop",  32'(drop_cnt),  32'd2);
    check("t4_valid", 32'(out_valid), 32'd0);
    check("t4_ack",   32'(ack),       32'd0);
    bus(1'b1, 8'h40);
    bus(1'b1, 8'h11);
    check("t4_ack_new", 32'(ack), 32'd1);
    check_head("t4_head", 8'h11, 1'b1, 2'b00);
    bus(1'b0, 8'h00);
    pop();
    check("t4_empty", 32'(out_valid), 32'd0);

    // Back-to-back frames with a ready consumer
    out_ready = 1'b1;
    bus(1'b1, 8'h41);
    bus(1'b1, 8'hA1);
    bus(1'b1, 8'hA2);
    check("t5_ack_a", 32'(ack), 32'd1);
    check_head("t5_a1", 8'hA1, 1'b0, 2'b00);
    bus(1'b1, 8'h50);
    check("t5_ack_gap", 32'(ack), 32'd0);
    check_head("t5_a2", 8'hA2, 1'b1, 2'b00);
    bus(1'b1, 8'hB1);
    check("t5_ack_b", 32'(ack), 32'd1);
    check_head("t5_b1", 8'hB1, 1'b1, 2'b01);
    bus(1'b0, 8'h00);
    check("t5_ack_end", 32'(ack),       32'd0);
    check("t5_empty",   32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a frame
    bus(1'b1, 8'h40);
    bus(1'b1, 8'h77);
    bus(1'b1, 8'h41);
    bus(1'b1, 8'h12);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data",  32'(out_data),  32'd0);
    check("t6_drop",  32'(drop_cnt),  32'd0);
    check("t6_ack",   32'(ack),       32'd0);
    @(negedge clk);
    bus_valid = 1'b0;
    rst_n = 1'b1;
    bus(1'b1, 8'h40);
    check("t6_hdr_ack", 32'(ack), 32'd0);
    bus(1'b1, 8'h99);
    check("t6_ack_new", 32'(ack), 32'd1);
    check_head("t6_head", 8'h99, 1'b1, 2'b00);
    bus(1'b0, 8'h00);
    pop();
    check("t6_empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_frame_responder.md
# bus_frame_responder

Receive-side endpoint for the shared crypto-interconnect byte bus. Snoops `bus_data`/`bus_valid` and parses frames:
- keeps frames addressed to its own ID;
- silently skips frames addressed to other IDs;
- buffers accepted payload in a commit/rollback FIFO;
- drives the bus `ack` pulse back to the transmitting `data_bus` instance once a frame is fully stored.

It is the responder for the `data_bus` initiators and feeds a local consumer (e.g. the SHA core) through a valid/ready byte stream.

## Interface
- `DEPTH`, 32: payload FIFO entries; power of two, ≥16 so one maximum-size frame always fits in an empty FIFO.
- `TIMEOUT`, 15: idle cycles (`bus_valid` low) tolerated mid-frame before abort; 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `my_id` in 2: this endpoint's bus ID; static after reset.
- `bus_data` in 8: shared bus byte.
- `bus_valid` in 1: qualifies `bus_data` for one cycle.
- `ack` out 1: one-cycle pulse; frame committed.
- `out_valid` out 1: FIFO head byte valid.
- `out_data` out 8: FIFO head byte.
- `out_last` out 1: head byte is the last byte of its frame.
- `out_src` out 2: source ID of the frame at the head.
- `out_ready` in 1: consumer accepts head byte when high with `out_valid`.
- `drop_cnt` out 8: saturating count of own-ID frames dropped (overflow or timeout).

## Operation
- **Frame format.** One header byte, then N payload bytes. Each byte is sampled on a `clk` edge with `bus_valid`=1.
  - Header [7:6] = dest ID.
  - Header [5:4] = src ID.
  - Header [3:0] = N−1, so N = 1..16.
- **FSM states:** IDLE, RECV, SKIP.
  - **IDLE**, valid header arrives:
    - dest==`my_id` and free ≥ N → RECV.
    - dest==`my_id` and free < N → SKIP, `drop_cnt`++.
    - dest≠`my_id` → SKIP, no count.
  - **RECV**: each valid byte is written at the speculative write pointer, with last = (remaining==1).
    - On the last byte: commit (committed ptr ← speculative ptr), set `ack` the next cycle, go to IDLE.
  - **SKIP**: count down N bytes without writing, then go to IDLE. No `ack`.
- **Byte counter.** Down-counter loaded with N at the header. The idle counter is reset by every valid byte.
- **Timeout.** In RECV or SKIP, `TIMEOUT` consecutive cycles with `bus_valid`=0 → go to IDLE.
  - RECV abort: speculative ptr ← committed ptr (rollback), `drop_cnt`++.
  - SKIP abort: no side effects.
- **Free space.** `free` = `DEPTH` − (committed wr ptr − rd ptr). It is evaluated only at the header. Reads during reception do not change that decision.
- **Read side.** Only committed entries are visible. `out_valid` = (rd ptr ≠ committed ptr). The pop happens on `out_valid && out_ready`.
- **Source ID.** `out_src` is the src ID latched at the header, stored per entry alongside data and last (11-bit FIFO word).
- **Pointers.** log2(`DEPTH`)+1 bits, wrap naturally. Full/empty are distinguished by the MSB.
- **Counter.** `drop_cnt` saturates at 255.

## Timing
- **Reset values:** `ack`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `out_src`=0, `drop_cnt`=0. State IDLE, all pointers 0, FIFO empty.
- **Header timing.** Header sampled at edge H; the first payload byte is accepted at edge H+1 at the earliest.
- **Ack latency.** Last payload byte sampled at edge L → `ack`=1 for exactly the cycle L..L+1 → first committed byte visible on `out_valid` after edge L.
- **Back-to-back frames.** FSM is in IDLE after edge L, so a new header may arrive at edge L+1, while `ack` is still high.
- **Same-cycle pop and write.** Legal; a pop in the commit cycle frees space for the next header.
- **Reset mid-frame.** All in-flight and buffered data is discarded; no `ack`.
- **Ack and abort are exclusive.** `ack` never asserts in the same cycle as an abort.

## Structure
- **Package `bus_pkg`:**
  - ID constants: `ID_B`=2'b00, `ID_SHA`=2'b01, `ID_CTRL`=2'b11.
  - Header field positions/widths and `MAX_LEN`=16.
  - FSM state enum.
  - FIFO word typedef {src, last, data}.
- **Sub-module `frame_fifo`:** synchronous FIFO with speculative write pointer, `commit`/`rollback` inputs and a `free` output.
- **Top-level FSM:** counters and `drop_cnt` stay in `bus_frame_responder`.

## Test plan
- **Single byte.** `my_id`=01; header 0x40 (dest 01, src 00, N=1), payload 0xA5 → `ack` pulse one cycle after 0xA5; out 0xA5, `out_last`=1, `out_src`=00.
- **Full frame, other ID.** Header 0x7F (N=16) from src 11 with payload 0x00..0x0F → `ack` after the 16th byte; 16 bytes popped in order, `out_last` only on 0x0F. Then header 0xC0 (dest 11) plus 1 byte → skipped, no `ack`, FIFO unchanged.
- **Overflow.** `DEPTH`=32, `out_ready`=0, two accepted 16-byte frames fill the FIFO. A third header 0x40 → SKIP, `drop_cnt`=1, no `ack`, the following payload byte is not parsed as a header.
- **Timeout.** Header 0x43 (N=4), 2 bytes, then `bus_valid` low 15 cycles → rollback, `out_valid` stays 0, `drop_cnt`++. Next frame 0x40,0x11 → accepted normally.
- **Back-to-back.** Frames at edges L and L+1 with `out_ready`=1 throughout → two `ack` pulses, byte order preserved.
- **Reset.** `rst_n` low mid-RECV → all outputs return to reset values immediately; a frame sent after release is received cleanly.
